// File: rtl/csr_file_m.sv
// Machine-mode CSR file: atomic RW/RS/RC access, trap entry/mret stack, registered irq sampling.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_file_m #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter logic [XLEN-1:0] MHARTID   = '0,
    parameter logic [XLEN-1:0] MISA_VAL  = XLEN'(32'h40001100)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            instret,
    input  logic            irq_ext,
    input  logic            irq_timer,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mret_pc,
    output logic            irq_pending,
    output logic [XLEN-1:0] irq_cause
);

    localparam int unsigned CNT_W = 64;
    localparam int unsigned HALF_W = 32;
    localparam bit          IS64  = (XLEN == 64);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1800);

    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic            r_meip;
    logic            r_mtip;

    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_rdata;
    logic            w_known;
    logic            w_ro;
    logic            w_is_write;
    logic            w_wr_en;
    logic [XLEN-1:0] w_wval;
    logic [XLEN-1:0] w_mstatus_nxt;
    logic [XLEN-1:0] w_base;
    logic            w_ext_pend;
    logic            w_tim_pend;

    assign w_mip = XLEN'({r_meip, 3'b000, r_mtip, 7'b000_0000});

`ifdef CSR_COUNTERS_EN
    logic [CNT_W-1:0] r_mcycle;
    logic [CNT_W-1:0] r_minstret;
    logic [CNT_W-1:0] w_cnt_wval;
`endif

    // Read mux, address decode and read-only classification
    always_comb begin
        w_rdata = '0;
        w_known = 1'b0;
        w_ro    = 1'b0;
        unique case (csr_addr)
            A_MSTATUS:  begin w_rdata = r_mstatus;  w_known = 1'b1; end
            A_MIE:      begin w_rdata = r_mie;      w_known = 1'b1; end
            A_MTVEC:    begin w_rdata = r_mtvec;    w_known = 1'b1; end
            A_MSCRATCH: begin w_rdata = r_mscratch; w_known = 1'b1; end
            A_MEPC:     begin w_rdata = r_mepc;     w_known = 1'b1; end
            A_MCAUSE:   begin w_rdata = r_mcause;   w_known = 1'b1; end
            A_MTVAL:    begin w_rdata = r_mtval;    w_known = 1'b1; end
            A_MIP:      begin w_rdata = w_mip;      w_known = 1'b1; w_ro = 1'b1; end
            A_MISA:     begin w_rdata = MISA_VAL;   w_known = 1'b1; w_ro = 1'b1; end
            A_MHARTID:  begin w_rdata = MHARTID;    w_known = 1'b1; w_ro = 1'b1; end
`ifdef CSR_COUNTERS_EN
            A_MCYCLE: begin
                w_rdata = IS64 ? XLEN'(r_mcycle) : XLEN'(r_mcycle[HALF_W-1:0]);
                w_known = 1'b1;
            end
            A_MINSTRET: begin
                w_rdata = IS64 ? XLEN'(r_minstret) : XLEN'(r_minstret[HALF_W-1:0]);
                w_known = 1'b1;
            end
            A_MCYCLEH: begin
                w_rdata = IS64 ? '0 : XLEN'(r_mcycle[CNT_W-1:HALF_W]);
                w_known = !IS64;
            end
            A_MINSTRETH: begin
                w_rdata = IS64 ? '0 : XLEN'(r_minstret[CNT_W-1:HALF_W]);
                w_known = !IS64;
            end
`endif
            default: begin
                w_rdata = '0;
                w_known = 1'b0;
            end
        endcase
    end

    // Write value for RW/RS/RC; RS/RC with a zero mask is not a write
    always_comb begin
        w_wval = csr_wdata;
        unique case (csr_op)
            2'b10:   w_wval = w_rdata | csr_wdata;
            2'b11:   w_wval = w_rdata & ~csr_wdata;
            default: w_wval = csr_wdata;
        endcase
    end

    assign w_is_write  = csr_valid && ((csr_op == 2'b01) || (csr_op[1] && (csr_wdata != '0)));
    assign w_wr_en     = w_is_write && w_known && !w_ro && !trap_valid && !mret;
    assign csr_rdata   = w_rdata;
    assign csr_illegal = !w_known || (w_is_write && w_ro);

    // mstatus next value: trap stacks MIE into MPIE, mret pops it back
    always_comb begin
        w_mstatus_nxt = r_mstatus;
        if (trap_valid) begin
            w_mstatus_nxt[7]     = r_mstatus[3];
            w_mstatus_nxt[3]     = 1'b0;
            w_mstatus_nxt[12:11] = 2'b11;
        end else if (mret) begin
            w_mstatus_nxt[3]     = r_mstatus[7];
            w_mstatus_nxt[7]     = 1'b1;
            w_mstatus_nxt[12:11] = 2'b11;
        end else if (w_wr_en && (csr_addr == A_MSTATUS)) begin
            w_mstatus_nxt = w_wval;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mstatus  <= MSTATUS_RST;
            r_mie      <= '0;
            r_mtvec    <= MTVEC_RST;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_meip     <= 1'b0;
            r_mtip     <= 1'b0;
        end else begin
            r_mstatus <= w_mstatus_nxt;
            r_meip    <= irq_ext;
            r_mtip    <= irq_timer;
            if (trap_valid) begin
                r_mepc   <= {trap_epc[XLEN-1:2], 2'b00};
                r_mcause <= trap_cause;
                r_mtval  <= trap_tval;
            end else if (w_wr_en) begin
                unique case (csr_addr)
                    A_MIE:      r_mie      <= w_wval;
                    A_MTVEC:    r_mtvec    <= w_wval;
                    A_MSCRATCH: r_mscratch <= w_wval;
                    A_MEPC:     r_mepc     <= {w_wval[XLEN-1:2], 2'b00};
                    A_MCAUSE:   r_mcause   <= w_wval;
                    A_MTVAL:    r_mtval    <= w_wval;
                    default:    ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    assign w_cnt_wval = CNT_W'(w_wval);

    // A write to one half replaces it and freezes the other half for that cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_wr_en && (csr_addr == A_MCYCLE)) begin
                r_mcycle <= IS64 ? w_cnt_wval
                                 : {r_mcycle[CNT_W-1:HALF_W], w_cnt_wval[HALF_W-1:0]};
            end else if (w_wr_en && (csr_addr == A_MCYCLEH) && !IS64) begin
                r_mcycle <= {w_cnt_wval[HALF_W-1:0], r_mcycle[HALF_W-1:0]};
            end else begin
                r_mcycle <= r_mcycle + CNT_W'(1);
            end

            if (w_wr_en && (csr_addr == A_MINSTRET)) begin
                r_minstret <= IS64 ? w_cnt_wval
                                   : {r_minstret[CNT_W-1:HALF_W], w_cnt_wval[HALF_W-1:0]};
            end else if (w_wr_en && (csr_addr == A_MINSTRETH) && !IS64) begin
                r_minstret <= {w_cnt_wval[HALF_W-1:0], r_minstret[HALF_W-1:0]};
            end else if (instret) begin
                r_minstret <= r_minstret + CNT_W'(1);
            end
        end
    end
`else
    logic w_unused_instret;
    assign w_unused_instret = instret;
`endif

    // Vectored mode only applies to interrupts
    assign w_base      = {r_mtvec[XLEN-1:2], 2'b00};
    assign trap_vector = ((r_mtvec[1:0] == 2'b01) && trap_cause[XLEN-1])
                         ? w_base + {trap_cause[XLEN-3:0], 2'b00}
                         : w_base;
    assign mret_pc     = r_mepc;

    assign w_ext_pend  = r_meip && r_mie[11];
    assign w_tim_pend  = r_mtip && r_mie[7];
    assign irq_pending = r_mstatus[3] && (w_ext_pend || w_tim_pend);
    assign irq_cause   = {1'b1, {(XLEN-5){1'b0}}, (w_ext_pend ? 4'd11 : 4'd7)};

endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: directed scenarios then randomized traffic vs. a CSR map model.
module tb_csr_file_m;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        instret;
    logic        irq_ext;
    logic        irq_timer;
    logic [31:0] trap_vector;
    logic [31:0] mret_pc;
    logic        irq_pending;
    logic [31:0] irq_cause;

    int checks = 0;
    int errors = 0;

    csr_file_m dut (
        .clk(clk), .rst(rst),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
        .mret(mret), .instret(instret), .irq_ext(irq_ext), .irq_timer(irq_timer),
        .trap_vector(trap_vector), .mret_pc(mret_pc),
        .irq_pending(irq_pending), .irq_cause(irq_cause)
    );

    always #5 clk = ~clk;

    // Reference model: writable CSRs in a map keyed by address
    logic [31:0] m_rw [int];
    logic        m_meip, m_mtip;
    logic [63:0] m_cyc, m_ins;

    function automatic void model_reset();
        m_rw.delete();
        m_rw['h300] = 32'h1800;
        m_rw['h304] = 0; m_rw['h305] = 0; m_rw['h340] = 0;
        m_rw['h341] = 0; m_rw['h342] = 0; m_rw['h343] = 0;
        m_meip = 0; m_mtip = 0; m_cyc = 0; m_ins = 0;
    endfunction

    function automatic bit m_ro(logic [11:0] a);
        return (a == 12'h344) || (a == 12'h301) || (a == 12'hF14);
    endfunction

    function automatic bit m_known(logic [11:0] a);
        if (m_ro(a) || m_rw.exists(int'(a))) return 1'b1;
`ifdef CSR_COUNTERS_EN
        if (a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(logic [11:0] a);
        if (a == 12'h344) return (32'(m_meip) << 11) | (32'(m_mtip) << 7);
        if (a == 12'h301) return 32'h4000_1100;
        if (a == 12'hF14) return 32'h0;
`ifdef CSR_COUNTERS_EN
        if (a == 12'hB00) return m_cyc[31:0];
        if (a == 12'hB80) return m_cyc[63:32];
        if (a == 12'hB02) return m_ins[31:0];
        if (a == 12'hB82) return m_ins[63:32];
`endif
        if (m_rw.exists(int'(a))) return m_rw[int'(a)];
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        csr_valid = 0; csr_op = 0; csr_addr = 12'h300; csr_wdata = 0;
        trap_valid = 0; trap_cause = 0; trap_epc = 0; trap_tval = 0;
        mret = 0; instret = 0;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_valid = 1; csr_op = op; csr_addr = a; csr_wdata = d;
    endtask

    // Check all outputs against the model, clock once, advance the model
    task automatic cycle();
        logic        real_wr, ext, tim;
        logic [31:0] old, wval, base, tv, ms, mie;
        #1;
        real_wr = csr_valid && (csr_op == 2'd1 || (csr_op[1] && csr_wdata != 0));
        old  = m_read(csr_addr);
        chk("rdata", csr_rdata, old);
        chk("illegal", csr_illegal, !m_known(csr_addr) || (real_wr && m_ro(csr_addr)));
        base = m_rw['h305] & ~32'h3;
        tv   = base;
        if (m_rw['h305][1:0] == 2'b01 && trap_cause[31]) tv = base + (trap_cause & 32'h7FFF_FFFF) * 4;
        chk("trap_vector", trap_vector, tv);
        chk("mret_pc", mret_pc, m_rw['h341]);
        mie = m_rw['h304];
        ms  = m_rw['h300];
        ext = m_meip && mie[11];
        tim = m_mtip && mie[7];
        chk("irq_pending", irq_pending, ms[3] && (ext || tim));
        chk("irq_cause", irq_cause, ext ? 32'h8000_000B : 32'h8000_0007);
        case (csr_op)
            2'd2:    wval = old | csr_wdata;
            2'd3:    wval = old & ~csr_wdata;
            default: wval = csr_wdata;
        endcase
        @(posedge clk);
        begin
            bit wr_ok, cw_lo, cw_hi, iw_lo, iw_hi;
            wr_ok = real_wr && m_known(csr_addr) && !m_ro(csr_addr) && !trap_valid && !mret;
            cw_lo = wr_ok && csr_addr == 12'hB00; cw_hi = wr_ok && csr_addr == 12'hB80;
            iw_lo = wr_ok && csr_addr == 12'hB02; iw_hi = wr_ok && csr_addr == 12'hB82;
            if (trap_valid) begin
                m_rw['h341] = trap_epc & ~32'h3;
                m_rw['h342] = trap_cause;
                m_rw['h343] = trap_tval;
                m_rw['h300] = (ms & ~32'h1888) | 32'h1800 | (ms[3] ? 32'h80 : 32'h0);
            end else if (mret) begin
                m_rw['h300] = (ms & ~32'h1888) | 32'h1880 | (ms[7] ? 32'h8 : 32'h0);
            end else if (wr_ok && m_rw.exists(int'(csr_addr))) begin
                m_rw[int'(csr_addr)] = (csr_addr == 12'h341) ? (wval & ~32'h3) : wval;
            end
            if (cw_lo) m_cyc[31:0] = wval; else if (cw_hi) m_cyc[63:32] = wval; else m_cyc = m_cyc + 1;
            if (iw_lo) m_ins[31:0] = wval; else if (iw_hi) m_ins[63:32] = wval;
            else if (instret) m_ins = m_ins + 1;
            m_meip = irq_ext; m_mtip = irq_timer;
        end
        @(negedge clk);
    endtask

    logic [11:0] addrs [0:13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                  12'h344, 12'h301, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82};

    initial begin
        idle(); irq_ext = 0; irq_timer = 0;
        rst = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;

        // Reset state
        csr_addr = 12'h300; #1 chk("rst_mstatus", csr_rdata, 32'h1800);
        chk("rst_irq_pending", irq_pending, 1'b0);
        cycle();
        csr_addr = 12'h305; #1 chk("rst_mtvec", csr_rdata, 32'h0);
        cycle();
        csr_addr = 12'h7C0; #1 chk("unk_rdata", csr_rdata, 32'h0);
        chk("unk_illegal", csr_illegal, 1'b1);
        cycle();

        // RW / RS / RC on mtvec
        csr(2'd1, 12'h305, 32'h8000_0101); cycle();
        csr(2'd2, 12'h305, 32'h2); #1 chk("rs_old", csr_rdata, 32'h8000_0101); cycle();
        csr(2'd3, 12'h305, 32'h3); #1 chk("rc_old", csr_rdata, 32'h8000_0103); cycle();
        idle(); csr_addr = 12'h305; #1 chk("rc_result", csr_rdata, 32'h8000_0100); cycle();

        // Trap with a same-cycle CSR write, then mret
        csr(2'd1, 12'h300, 32'h1808); cycle();
        csr(2'd1, 12'h341, 32'h1234);
        trap_valid = 1; trap_cause = 2; trap_epc = 32'h8000_0016; trap_tval = 32'h55; cycle();
        idle(); csr_addr = 12'h341; #1 chk("trap_mepc", csr_rdata, 32'h8000_0014); cycle();
        csr_addr = 12'h342; #1 chk("trap_mcause", csr_rdata, 32'h2); cycle();
        csr_addr = 12'h300; #1 chk("trap_mstatus", csr_rdata, 32'h1880);
        mret = 1; cycle();
        idle(); csr_addr = 12'h300; #1 chk("mret_mstatus", csr_rdata, 32'h1888);
        chk("mret_pc_val", mret_pc, 32'h8000_0014); cycle();

        // Vectored interrupt, external beats timer
        csr(2'd1, 12'h305, 32'h8000_0001); cycle();
        csr(2'd1, 12'h300, 32'h1808); cycle();
        csr(2'd1, 12'h304, 32'h880); cycle();
        idle(); irq_ext = 1; irq_timer = 1; #1 chk("irq_latency", irq_pending, 1'b0); cycle();
        trap_cause = 32'h8000_000B;
        #1 chk("irq_pend", irq_pending, 1'b1);
        chk("irq_cause_ext", irq_cause, 32'h8000_000B);
        chk("vec_target", trap_vector, 32'h8000_002C);
        cycle();
        idle(); irq_ext = 0; cycle(); cycle();

        // Read-only CSR writes
        csr(2'd1, 12'hF14, 32'h5); #1 chk("ro_rw_illegal", csr_illegal, 1'b1); cycle();
        csr(2'd2, 12'hF14, 32'h0); #1 chk("ro_rs0_illegal", csr_illegal, 1'b0);
        chk("ro_unchanged", csr_rdata, 32'h0); cycle();

`ifdef CSR_COUNTERS_EN
        csr(2'd1, 12'hB00, 32'hFFFF_FFFF); cycle();
        csr(2'd1, 12'hB80, 32'h0); cycle();
        idle(); cycle(); cycle();
        csr_addr = 12'hB80; #1 chk("mcycleh", csr_rdata, 32'h1);
        csr_addr = 12'hB00; #1 chk("mcycle", csr_rdata, 32'h1);
        cycle();
        instret = 1; cycle(); cycle(); cycle();
        idle(); csr_addr = 12'hB02; #1 chk("minstret", csr_rdata, 32'h3); cycle();
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            idle();
            csr_valid = ($urandom_range(0, 3) != 0);
            csr_op    = 2'($urandom_range(0, 3));
            csr_addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 13)];
            csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 15) == 0) begin
                trap_valid = 1;
                trap_cause = {1'($urandom), 31'($urandom_range(0, 15))};
                trap_epc   = $urandom;
                trap_tval  = $urandom;
            end else begin
                trap_cause = {1'($urandom), 31'($urandom)};
            end
            mret      = ($urandom_range(0, 15) == 0);
            instret   = 1'($urandom);
            irq_ext   = ($urandom_range(0, 3) == 0);
            irq_timer = ($urandom_range(0, 3) == 0);
            cycle();
        end

        // Asynchronous reset mid-run
        idle(); irq_ext = 0; irq_timer = 0;
        #2 rst = 0;
        #1 model_reset();
        csr_addr = 12'h300; #1 chk("arst_mstatus", csr_rdata, 32'h1800);
        chk("arst_irq", irq_pending, 1'b0);
        @(negedge clk); rst = 1;
        csr_addr = 12'h341; cycle();
        csr_addr = 12'h305; cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
